// File: rtl/xor_bist_ctrl_if.sv
// xor_bist_ctrl_if: host and cell-side signals of the XOR self-test controller.
// master = controller, slave = host plus XOR cell.
interface xor_bist_ctrl_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             dut_x;
  logic             dut_y;
  logic             dut_z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_fail;

  modport master (
    input  start,
    input  dut_z,
    output dut_x,
    output dut_y,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail
  );

  modport slave (
    output start,
    output dut_z,
    input  dut_x,
    input  dut_y,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail
  );
endinterface

// File: rtl/xor_bist_ctrl.sv
// xor_bist_ctrl: walks a 2-input XOR cell through 00,01,10,11 and counts mismatches.
// Define XOR_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module xor_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 8
) (
  input logic             clk,
  input logic             reset,
  xor_bist_ctrl_if.master bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rnd;
  logic             x_q;
  logic             y_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [1:0]       ff_q;

  logic             mismatch;
  logic             last_vec;
  logic             stop;
  logic [1:0]       vec_nxt;
  logic [ERR_W-1:0] err_nxt;

  assign mismatch = bus.dut_z != (x_q ^ y_q);
  assign last_vec = x_q & y_q & (rnd == RND_LAST);
  assign vec_nxt  = {x_q, y_q} + 2'd1;
  assign err_nxt  = (mismatch && !(&err_q)) ? err_q + 1'b1 : err_q;

`ifdef XOR_BIST_STOP_ON_FAIL_EN
  assign stop = last_vec | mismatch;
`else
  assign stop = last_vec;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rnd    <= '0;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      ff_q   <= 2'b00;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= SETTLE;
            cnt    <= '0;
            rnd    <= '0;
            x_q    <= 1'b0;
            y_q    <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ff_q   <= 2'b00;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          err_q <= err_nxt;
          // err_q only leaves zero on the first mismatch of a run
          if (mismatch && (err_q == '0)) begin
            ff_q <= {x_q, y_q};
          end
          if (stop) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_nxt == '0);
          end else begin
            state <= SETTLE;
            cnt   <= '0;
            x_q   <= vec_nxt[1];
            y_q   <= vec_nxt[0];
            if (x_q & y_q) begin
              rnd <= rnd + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.dut_x      = x_q;
  assign bus.dut_y      = y_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_xor_bist_ctrl.sv
// tb_xor_bist_ctrl: scoreboard bench for the XOR self-test controller.
// Instance a uses defaults; instance b uses ROUNDS=2, ERR_W=2.
module tb_xor_bist_ctrl;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   mode_a;
  int   mode_b;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  always #5 clk = ~clk;

  xor_bist_ctrl_if #(.ERR_W(8)) ba ();
  xor_bist_ctrl_if #(.ERR_W(2)) bb ();

  // 0 = XOR, 1 = stuck-at-0, 2 = stuck-at-1, 3 = XNOR
  function automatic logic model(input int m, input logic x, input logic y);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    if (m == 3) return ~(x ^ y);
    return x ^ y;
  endfunction

  assign ba.dut_z = model(mode_a, ba.dut_x, ba.dut_y);
  assign bb.dut_z = model(mode_b, bb.dut_x, bb.dut_y);

  xor_bist_ctrl u_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (ba)
  );

  xor_bist_ctrl #(
    .SETTLE_CYCLES(2),
    .ROUNDS       (2),
    .ERR_W        (2)
  ) u_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (bb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vecs(input int nvec);
    for (int v = 0; v < nvec; v++) begin
      for (int s = 0; s < 3; s++) begin
        exp_q.push_back(2'(v % 4));
      end
    end
  endtask

  task automatic run_a(output int cyc);
    obs_q.delete();
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    cyc = 0;
    while (ba.busy === 1'b1 && cyc < 300) begin
      obs_q.push_back({ba.dut_x, ba.dut_y});
      tick();
      cyc++;
    end
  endtask

  task automatic run_b(output int cyc);
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    cyc = 0;
    while (bb.busy === 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    ba.start = 1'b1;
    bb.start = 1'b0;
    tick();
    tick();
    ba.start = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    checks++;
    if (ba.busy !== 1'b0 || ba.done !== 1'b0 || ba.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b pass=%b want 000",
               ba.busy, ba.done, ba.pass);
    end
    checks++;
    if (ba.err_count !== 8'd0 || ba.first_fail !== 2'b00) begin
      errors++;
      $display("FAIL reset_counts: got err=%0d ff=%b want 0 00",
               ba.err_count, ba.first_fail);
    end
    checks++;
    if ({ba.dut_x, ba.dut_y} !== 2'b00 || bb.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vec: got xy=%b busy_b=%b want 00 0",
               {ba.dut_x, ba.dut_y}, bb.busy);
    end
  endtask

  task automatic test_good_xor();
    int cyc;
    logic [1:0] o;
    logic [1:0] e;
    mode_a = 0;
    exp_q.delete();
    push_vecs(4);
    run_a(cyc);
    checks++;
    if (cyc !== 12) begin
      errors++;
      $display("FAIL good_busy_len: got %0d want 12", cyc);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL good_vec_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL good_vec: got %b want %b", o, e);
      end
    end
    checks++;
    if (ba.done !== 1'b1 || ba.pass !== 1'b1 || ba.err_count !== 8'd0) begin
      errors++;
      $display("FAIL good_result: got done=%b pass=%b err=%0d want 1 1 0",
               ba.done, ba.pass, ba.err_count);
    end
    repeat (3) tick();
    checks++;
    if (ba.done !== 1'b1 || {ba.dut_x, ba.dut_y} !== 2'b11 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL good_hold: got done=%b xy=%b busy=%b want 1 11 0",
               ba.done, {ba.dut_x, ba.dut_y}, ba.busy);
    end
  endtask

  task automatic test_stuck0();
    int cyc;
    int exp_cyc;
    logic [7:0] exp_err;
    logic [1:0] o;
    logic [1:0] e;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    exp_cyc = 6;
    exp_err = 8'd1;
`else
    exp_cyc = 12;
    exp_err = 8'd2;
`endif
    mode_a = 1;
    exp_q.delete();
    push_vecs(exp_cyc / 3);
    run_a(cyc);
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL s0_busy_len: got %0d want %0d", cyc, exp_cyc);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL s0_vec: got %b want %b", o, e);
      end
    end
    checks++;
    if (ba.done !== 1'b1 || ba.pass !== 1'b0) begin
      errors++;
      $display("FAIL s0_flags: got done=%b pass=%b want 1 0", ba.done, ba.pass);
    end
    checks++;
    if (ba.err_count !== exp_err || ba.first_fail !== 2'b01) begin
      errors++;
      $display("FAIL s0_counts: got err=%0d ff=%b want %0d 01",
               ba.err_count, ba.first_fail, exp_err);
    end
  endtask

  task automatic test_xnor_saturate();
    int cyc;
    int exp_cyc;
    logic [1:0] exp_err;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    exp_cyc = 3;
    exp_err = 2'd1;
`else
    exp_cyc = 24;
    exp_err = 2'd3;
`endif
    mode_b = 3;
    run_b(cyc);
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL xnor_busy_len: got %0d want %0d", cyc, exp_cyc);
    end
    checks++;
    if (bb.err_count !== exp_err || bb.first_fail !== 2'b00) begin
      errors++;
      $display("FAIL xnor_counts: got err=%0d ff=%b want %0d 00",
               bb.err_count, bb.first_fail, exp_err);
    end
    checks++;
    if (bb.done !== 1'b1 || bb.pass !== 1'b0) begin
      errors++;
      $display("FAIL xnor_flags: got done=%b pass=%b want 1 0", bb.done, bb.pass);
    end
  endtask

  task automatic test_restart_and_abort();
    int cyc;
    mode_a = 0;
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    repeat (4) tick();
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    checks++;
    if ({ba.dut_x, ba.dut_y} !== 2'b01 || ba.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_ignored: got xy=%b busy=%b want 01 1",
               {ba.dut_x, ba.dut_y}, ba.busy);
    end
    repeat (2) tick();
    checks++;
    if ({ba.dut_x, ba.dut_y} !== 2'b10) begin
      errors++;
      $display("FAIL pre_abort_vec: got %b want 10", {ba.dut_x, ba.dut_y});
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    checks++;
    if (ba.busy !== 1'b0 || ba.done !== 1'b0 || ba.err_count !== 8'd0 ||
        {ba.dut_x, ba.dut_y} !== 2'b00) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b err=%0d xy=%b want 0 0 0 00",
               ba.busy, ba.done, ba.err_count, {ba.dut_x, ba.dut_y});
    end
    repeat (5) tick();
    checks++;
    if (ba.busy !== 1'b0 || ba.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resume: got busy=%b done=%b want 0 0", ba.busy, ba.done);
    end
    run_a(cyc);
    checks++;
    if (cyc !== 12 || ba.pass !== 1'b1) begin
      errors++;
      $display("FAIL after_abort_run: got len=%0d pass=%b want 12 1", cyc, ba.pass);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode_a = 1;
    run_a(cyc);
    checks++;
    if (ba.done !== 1'b1 || ba.err_count === 8'd0) begin
      errors++;
      $display("FAIL b2b_first_run: got done=%b err=%0d want 1 nonzero",
               ba.done, ba.err_count);
    end
    mode_a = 0;
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    checks++;
    if (ba.err_count !== 8'd0 || ba.done !== 1'b0 || ba.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got err=%0d done=%b busy=%b want 0 0 1",
               ba.err_count, ba.done, ba.busy);
    end
    cyc = 1;
    while (ba.busy === 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 13 || ba.pass !== 1'b1 || ba.err_count !== 8'd0) begin
      errors++;
      $display("FAIL b2b_second_run: got edges=%0d pass=%b err=%0d want 13 1 0",
               cyc, ba.pass, ba.err_count);
    end
  endtask

`ifdef XOR_BIST_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    int cyc;
    mode_a = 2;
    run_a(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL sof_busy_len: got %0d want 3", cyc);
    end
    repeat (2) tick();
    checks++;
    if (ba.err_count !== 8'd1 || ba.first_fail !== 2'b00 || ba.pass !== 1'b0) begin
      errors++;
      $display("FAIL sof_counts: got err=%0d ff=%b pass=%b want 1 00 0",
               ba.err_count, ba.first_fail, ba.pass);
    end
    checks++;
    if (ba.done !== 1'b1 || {ba.dut_x, ba.dut_y} !== 2'b00) begin
      errors++;
      $display("FAIL sof_hold: got done=%b xy=%b want 1 00",
               ba.done, {ba.dut_x, ba.dut_y});
    end
  endtask
`endif

  initial begin
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    mode_a   = 0;
    mode_b   = 0;
    ba.start = 1'b0;
    bb.start = 1'b0;
    test_reset();
    test_good_xor();
    test_stuck0();
    test_xnor_saturate();
    test_restart_and_abort();
    test_back_to_back();
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    test_stop_on_fail();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xor_bist_ctrl.md
Name: xor_bist_ctrl

Overview:
- Hardware built-in self-test controller for the 2-input XOR cell: drives dut_x/dut_y through the four input vectors, samples dut_z after a settle window, and compares against x^y.
- Checking moves from the simulation bench into synthesizable logic, so the same check runs on the FPGA.
- Sits beside the XOR cell; a host or button logic pulses start and reads done/pass/err_count.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before dut_z is sampled; legal range >= 1.
- ROUNDS, 1, number of complete passes over the four vectors; legal range >= 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- dut_x  output  1  registered stimulus to the DUT x input.
- dut_y  output  1  registered stimulus to the DUT y input.
- dut_z  input  1  DUT response.
- busy  output  1  high while a run is in progress.
- done  output  1  high when a run has completed; held until the next start or reset.
- pass  output  1  done && (err_count == 0).
- err_count  output  ERR_W  number of mismatches in the current or last run; saturating.
- first_fail  output  2  {x,y} vector of the first mismatch; valid only when err_count != 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; dut_x=0, dut_y=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
- Vector order within each round: {x,y} = 00, 01, 10, 11. Expected response is x^y.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 moves to SETTLE.
  - On entry to SETTLE: load vector 00 onto dut_x/dut_y, clear err_count, first_fail, round counter and settle counter; busy=1.
- SETTLE: holds the vector for SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1), then goes to CHECK.
- CHECK (one cycle): samples dut_z and compares it with dut_x^dut_y.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - If this is the first mismatch of the run, first_fail captures {dut_x,dut_y}.
  - If vector=11 and round=ROUNDS-1: go to DONE.
  - Otherwise: advance the vector (11 wraps to 00 and increments round), drive it on the next edge, clear the settle counter, and return to SETTLE.
- DONE: busy=0, done=1; outputs held. start=1 restarts exactly as from IDLE, clearing done the same cycle the new run begins.
- Latency: busy is high for ROUNDS*4*(SETTLE_CYCLES+1) cycles. With defaults that is 12 cycles; done rises on the 13th edge after the start edge.
- start while busy is ignored (no restart, no effect on counts).
- dut_x/dut_y change only on SETTLE entry. They hold their last value (11) in DONE and return to 00 only on reset.
- Reset mid-run: the synchronous reset aborts the run and returns all outputs to reset values on the next edge; a run never resumes.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: XOR_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. err_count=1, first_fail=the failing vector, pass=0, and the remaining vectors are not applied.
- Undefined: all vectors of all rounds are always applied and every mismatch is counted.

Test Plan:
1. Correct XOR DUT, defaults, start pulse -> busy high 12 cycles, then done=1, pass=1, err_count=0; dut_x/dut_y observed 00,01,10,11 for 3 cycles each.
2. dut_z stuck at 0 -> done, pass=0, err_count=2, first_fail=2'b01.
3. XNOR DUT (dut_z = ~(x^y)), ROUNDS=2, ERR_W=2 -> 8 mismatches saturate at err_count=3; first_fail=2'b00; done after 24 busy cycles.
4. Correct DUT; start re-pulsed at busy cycle 5; then reset asserted at busy cycle 8 -> second start has no effect; after reset, busy=0, done=0, err_count=0, dut_x=dut_y=0. A new start then completes with pass=1.
5. Stuck-at-0 run completes, then start in DONE with a correct DUT -> err_count cleared on the new run's first cycle; the second run ends with pass=1, err_count=0.
6. With XOR_BIST_STOP_ON_FAIL_EN defined, dut_z stuck at 1 -> done at the first CHECK (busy 3 cycles), err_count=1, first_fail=2'b00, dut_x=dut_y=0 held.
